// File: rtl/ex_mdu_pkg.sv
// Shared operation codes and MDU sequencing state encoding for the execute stage.
package ex_mdu_pkg;

    localparam int ALU_CODE_W = 5;

    localparam logic [ALU_CODE_W-1:0] ALU_SLL   = 5'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL   = 5'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA   = 5'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 5'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 5'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_AND   = 5'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_OR    = 5'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR   = 5'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR   = 5'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT   = 5'd9;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU  = 5'd10;
    localparam logic [ALU_CODE_W-1:0] ALU_JAL   = 5'd11;
    localparam logic [ALU_CODE_W-1:0] ALU_LW    = 5'd12;
    localparam logic [ALU_CODE_W-1:0] ALU_SW    = 5'd13;
    localparam logic [ALU_CODE_W-1:0] ALU_MULT  = 5'd14;
    localparam logic [ALU_CODE_W-1:0] ALU_MULTU = 5'd15;
    localparam logic [ALU_CODE_W-1:0] ALU_DIV   = 5'd16;
    localparam logic [ALU_CODE_W-1:0] ALU_DIVU  = 5'd17;
    localparam logic [ALU_CODE_W-1:0] ALU_MFHI  = 5'd18;
    localparam logic [ALU_CODE_W-1:0] ALU_MFLO  = 5'd19;
    localparam logic [ALU_CODE_W-1:0] ALU_MTHI  = 5'd20;
    localparam logic [ALU_CODE_W-1:0] ALU_MTLO  = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/ex_mdu_if.sv
// Execute-stage bus: instruction operands in, ALU/memory results, stall and HI/LO out.
interface ex_mdu_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
);
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] pc;
    logic [OPW-1:0]   aluop;
    logic [WIDTH-1:0] opr1;
    logic [WIDTH-1:0] opr2;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] alures;
    logic             m_wen;
    logic [WIDTH-1:0] m_addr;
    logic [WIDTH-1:0] m_dout;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, in_valid, pc, aluop, opr1, opr2, offset,
        input  alures, m_wen, m_addr, m_dout, stall, hi, lo
    );

    modport slave (
        input  flush, in_valid, pc, aluop, opr1, opr2, offset,
        output alures, m_wen, m_addr, m_dout, stall, hi, lo
    );
endinterface

// File: rtl/ex_mdu_md_iter.sv
// Iterative radix-2 multiply/divide on operand magnitudes, with sign fix-up
// and divide-by-zero result applied on the way out.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // acc holds the product high half / running remainder; mq holds the
    // multiplier shifting out as product low bits shift in, or the dividend
    // shifting out as quotient bits shift in.
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             div_q;
    logic             neg_lo;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_trial;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes and the per-step adder/subtractor.
    always_comb begin
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        add_sum   = {1'b0, acc} + {1'b0, dvs};
        sub_trial = {acc, mq[WIDTH-1]} - {1'b0, dvs};
    end

    // Load on start, then one shift-add or restoring-divide step per cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            busy_q   <= 1'b0;
            div_q    <= 1'b0;
            neg_lo   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            dvs      <= '0;
            a_raw    <= '0;
        end else if (abort) begin
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            cnt      <= CW'(WIDTH - 1);
            busy_q   <= 1'b1;
            div_q    <= is_div;
            neg_lo   <= a_neg ^ b_neg;
            neg_rem  <= is_div & a_neg;
            div_zero <= is_div & (b == '0);
            acc      <= '0;
            mq       <= a_mag;
            dvs      <= b_mag;
            a_raw    <= a;
        end else if (busy_q) begin
            if (div_q) begin
                if (!sub_trial[WIDTH]) begin
                    acc <= sub_trial[WIDTH-1:0];
                    mq  <= {mq[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= {acc[WIDTH-2:0], mq[WIDTH-1]};
                    mq  <= {mq[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (mq[0]) begin
                    acc <= add_sum[WIDTH:1];
                    mq  <= {add_sum[0], mq[WIDTH-1:1]};
                end else begin
                    acc <= {1'b0, acc[WIDTH-1:1]};
                    mq  <= {acc[0], mq[WIDTH-1:1]};
                end
            end
            if (cnt == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Signed fix-up; divide by zero reports all-ones quotient and the raw dividend.
    always_comb begin
        prod   = {acc, mq};
        hi_res = '0;
        lo_res = '0;
        if (!div_q) begin
            {hi_res, lo_res} = neg_lo ? -prod : prod;
        end else if (div_zero) begin
            lo_res = '1;
            hi_res = a_raw;
        end else begin
            lo_res = neg_lo  ? -mq  : mq;
            hi_res = neg_rem ? -acc : acc;
        end
    end

    assign busy = busy_q;
    assign done = busy_q & (cnt == '0);

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: combinational ALU and load/store address path, plus HI/LO
// registers fed by the iterative multiply/divide unit.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no MDU op in flight; MDU ops and MTHI/MTLO accepted here
//   BUSY    | md_iter stepping, upstream frozen via stall
//   DONE    | result ready; HI/LO written at the edge leaving this state
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic     clk,
    input  logic     resetn,
    ex_mdu_if.slave  bus
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_t       state_q, state_d;
    logic             accept;
    logic             is_mdu, is_div_op, is_signed_op;
    logic             start, abort;
    logic             iter_busy, iter_done;
    logic [WIDTH-1:0] hi_q, lo_q, hi_res, lo_res;
    logic [WIDTH-1:0] alures;
    logic [SHW-1:0]   sh;

    assign accept = bus.in_valid & ~bus.flush;
    assign sh     = bus.opr1[SHW-1:0];

    // Classify multi-cycle ops.
    always_comb begin
        is_mdu       = 1'b0;
        is_div_op    = 1'b0;
        is_signed_op = 1'b0;
        case (bus.aluop)
            OPW'(ALU_MULT):  begin is_mdu = 1'b1; is_signed_op = 1'b1; end
            OPW'(ALU_MULTU): begin is_mdu = 1'b1; end
            OPW'(ALU_DIV):   begin is_mdu = 1'b1; is_div_op = 1'b1; is_signed_op = 1'b1; end
            OPW'(ALU_DIVU):  begin is_mdu = 1'b1; is_div_op = 1'b1; end
            default: ;
        endcase
    end

    // Single-cycle ALU result, including HI/LO reads.
    always_comb begin
        alures = '0;
        case (bus.aluop)
            OPW'(ALU_SLL):  alures = bus.opr2 << sh;
            OPW'(ALU_SRL):  alures = bus.opr2 >> sh;
            OPW'(ALU_SRA):  alures = $signed(bus.opr2) >>> sh;
            OPW'(ALU_ADD):  alures = bus.opr1 + bus.opr2;
            OPW'(ALU_SUB):  alures = bus.opr1 - bus.opr2;
            OPW'(ALU_AND):  alures = bus.opr1 & bus.opr2;
            OPW'(ALU_OR):   alures = bus.opr1 | bus.opr2;
            OPW'(ALU_XOR):  alures = bus.opr1 ^ bus.opr2;
            OPW'(ALU_NOR):  alures = ~(bus.opr1 | bus.opr2);
            OPW'(ALU_SLT):  alures = {{(WIDTH-1){1'b0}}, ($signed(bus.opr1) < $signed(bus.opr2))};
            OPW'(ALU_SLTU): alures = {{(WIDTH-1){1'b0}}, (bus.opr1 < bus.opr2)};
            OPW'(ALU_JAL):  alures = bus.pc + WIDTH'(8);
            OPW'(ALU_MFHI): alures = hi_q;
            OPW'(ALU_MFLO): alures = lo_q;
            default:        alures = '0;
        endcase
    end

    // Memory request, killed when the instruction is invalid or flushed.
    always_comb begin
        bus.m_wen  = 1'b0;
        bus.m_addr = '0;
        bus.m_dout = '0;
        if (accept) begin
            case (bus.aluop)
                OPW'(ALU_LW): bus.m_addr = bus.opr1 + bus.offset;
                OPW'(ALU_SW): begin
                    bus.m_addr = bus.opr1 + bus.offset;
                    bus.m_dout = bus.opr2;
                    bus.m_wen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // MDU sequencing state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and md_iter start/abort strobes.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mdu) begin
                    state_d = ST_BUSY;
                    start   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end else if (iter_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // HI/LO: commit MDU result leaving DONE, or direct moves while IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == ST_DONE && !bus.flush) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
        end else if (state_q == ST_IDLE && accept) begin
            if (bus.aluop == OPW'(ALU_MTHI)) hi_q <= bus.opr1;
            if (bus.aluop == OPW'(ALU_MTLO)) lo_q <= bus.opr1;
        end
    end

    md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .is_div    (is_div_op),
        .is_signed (is_signed_op),
        .a         (bus.opr1),
        .b         (bus.opr2),
        .busy      (iter_busy),
        .done      (iter_done),
        .hi_res    (hi_res),
        .lo_res    (lo_res)
    );

    // Stall covers the accepting cycle and all of BUSY; forced low in reset.
    assign bus.stall  = resetn & (((state_q == ST_IDLE) & accept & is_mdu) |
                                  ((state_q == ST_BUSY) & iter_busy));
    assign bus.alures = alures;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: ALU, memory path, MDU ops, flush, reset, back-to-back.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mdu_if #(.WIDTH(W), .OPW(5)) bus ();

    ex_mdu #(.WIDTH(W), .OPW(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } mdu_vec_t;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.aluop    = op;
        bus.opr1     = a;
        bus.opr2     = b;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.aluop    = ALU_ADD;
        bus.opr1     = '0;
        bus.opr2     = '0;
        bus.offset   = '0;
        bus.pc       = '0;
    endtask

    // Presents an MDU op in the current cycle and holds it while stalled;
    // returns at the cycle after DONE with the op still on the inputs.
    task automatic run_mdu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int n);
        drive(op, a, b);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
            n++;
            next_cycle();
        end
        next_cycle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp %h", bus.hi, 32'h0); end
        checks++;
        if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp %h", bus.lo, 32'h0); end
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    endtask

    task automatic test_alu();
        alu_vec_t v[13] = '{
            '{ALU_ADD,  32'd5,        32'd7,        32'd12},
            '{ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE},
            '{ALU_SLL,  32'd4,        32'd1,        32'h10},
            '{ALU_SRL,  32'd4,        32'h80000000, 32'h08000000},
            '{ALU_SRA,  32'd4,        32'h80000000, 32'hF8000000},
            '{ALU_AND,  32'hF0F0,     32'hFF00,     32'hF000},
            '{ALU_OR,   32'hF0F0,     32'h0F00,     32'hFFF0},
            '{ALU_XOR,  32'hFF00,     32'h0FF0,     32'hF0F0},
            '{ALU_NOR,  32'h0,        32'h0,        32'hFFFFFFFF},
            '{ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1},
            '{ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0},
            '{ALU_JAL,  32'd0,        32'd0,        32'h408},
            '{5'd31,    32'd5,        32'd7,        32'd0}
        };
        bus.pc = 32'h400;
        for (int i = 0; i < 13; i++) begin
            drive(v[i].op, v[i].a, v[i].b);
            @(negedge clk);
            checks++;
            if (bus.alures !== v[i].exp) begin
                errors++;
                $display("FAIL alu_op%0d got %h exp %h", v[i].op, bus.alures, v[i].exp);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_mem();
        drive(ALU_SW, 32'h100, 32'hAB);
        bus.offset = 32'hFFFFFFFC;
        @(negedge clk);
        checks++;
        if (bus.m_addr !== 32'hFC) begin errors++; $display("FAIL sw_addr got %h exp %h", bus.m_addr, 32'hFC); end
        checks++;
        if (bus.m_dout !== 32'hAB) begin errors++; $display("FAIL sw_dout got %h exp %h", bus.m_dout, 32'hAB); end
        checks++;
        if (bus.m_wen !== 1'b1) begin errors++; $display("FAIL sw_wen got %b exp 1", bus.m_wen); end
        next_cycle();
        bus.aluop = ALU_LW;
        @(negedge clk);
        checks++;
        if (bus.m_addr !== 32'hFC || bus.m_wen !== 1'b0 || bus.m_dout !== 32'h0) begin
            errors++;
            $display("FAIL lw_req got addr %h wen %b dout %h exp addr fc wen 0 dout 0",
                     bus.m_addr, bus.m_wen, bus.m_dout);
        end
        next_cycle();
        bus.aluop = ALU_SW;
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_addr !== 32'h0 || bus.m_wen !== 1'b0 || bus.m_dout !== 32'h0) begin
            errors++;
            $display("FAIL sw_flushed got addr %h wen %b dout %h exp all zero",
                     bus.m_addr, bus.m_wen, bus.m_dout);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_mdu_ops();
        mdu_vec_t v[6] = '{
            '{ALU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1},
            '{ALU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14},
            '{ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
            '{ALU_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF},
            '{ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
            '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000}
        };
        int n;
        for (int i = 0; i < 6; i++) begin
            run_mdu(v[i].op, v[i].a, v[i].b, n);
            bus.aluop = ALU_MFHI;
            @(negedge clk);
            checks++;
            if (n != 33) begin errors++; $display("FAIL mdu%0d_stall_cycles got %0d exp 33", i, n); end
            checks++;
            if (bus.hi !== v[i].exp_hi) begin errors++; $display("FAIL mdu%0d_hi got %h exp %h", i, bus.hi, v[i].exp_hi); end
            checks++;
            if (bus.lo !== v[i].exp_lo) begin errors++; $display("FAIL mdu%0d_lo got %h exp %h", i, bus.lo, v[i].exp_lo); end
            checks++;
            if (bus.alures !== v[i].exp_hi) begin errors++; $display("FAIL mdu%0d_mfhi got %h exp %h", i, bus.alures, v[i].exp_hi); end
            next_cycle();
            bus.aluop = ALU_MFLO;
            @(negedge clk);
            checks++;
            if (bus.alures !== v[i].exp_lo) begin errors++; $display("FAIL mdu%0d_mflo got %h exp %h", i, bus.alures, v[i].exp_lo); end
            next_cycle();
            idle();
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        run_mdu(ALU_MULTU, 32'd6, 32'd7, n1);
        checks++;
        if (bus.lo !== 32'd42) begin errors++; $display("FAIL b2b_first_lo got %h exp %h", bus.lo, 32'd42); end
        run_mdu(ALU_DIVU, 32'd100, 32'd7, n2);
        idle();
        @(negedge clk);
        checks++;
        if (n1 != 33 || n2 != 33) begin errors++; $display("FAIL b2b_stall_cycles got %0d/%0d exp 33/33", n1, n2); end
        checks++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errors++;
            $display("FAIL b2b_second got hi %h lo %h exp hi 2 lo e", bus.hi, bus.lo);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        drive(ALU_MTHI, 32'h1234, 32'h0);
        next_cycle();
        drive(ALU_MTLO, 32'h5678, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h exp %h", bus.hi, 32'h1234); end
        next_cycle();
        checks++;
        if (bus.lo !== 32'h5678) begin errors++; $display("FAIL mtlo got %h exp %h", bus.lo, 32'h5678); end
        // Flushed in IDLE: neither MTHI nor an MDU op is taken.
        drive(ALU_MTHI, 32'hDEAD, 32'h0);
        bus.flush = 1'b1;
        next_cycle();
        bus.aluop = ALU_MULT;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.hi !== 32'h1234) begin
            errors++;
            $display("FAIL idle_flush got stall %b hi %h exp stall 0 hi 1234", bus.stall, bus.hi);
        end
        next_cycle();
        bus.flush = 1'b0;
        drive(ALU_MULT, 32'd2, 32'd3);
        next_cycle();
        repeat (9) next_cycle();
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_busy_stall got %b exp 1", bus.stall); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall_drop got %b exp 0", bus.stall); end
        repeat (40) next_cycle();
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
            errors++;
            $display("FAIL flush_hilo got hi %h lo %h exp hi 1234 lo 5678", bus.hi, bus.lo);
        end
        drive(ALU_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.alures !== 32'h1234) begin errors++; $display("FAIL flush_mfhi got %h exp %h", bus.alures, 32'h1234); end
        next_cycle();
        idle();
    endtask

    task automatic test_reset_mid_op();
        int n;
        drive(ALU_DIV, 32'd100, 32'd7);
        repeat (10) next_cycle();
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL midreset_hilo got hi %h lo %h exp 0 0", bus.hi, bus.lo);
        end
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL midreset_stall got %b exp 0", bus.stall); end
        next_cycle();
        idle();
        resetn = 1'b1;
        next_cycle();
        run_mdu(ALU_MULT, 32'hFFFFFFFF, 32'd6, n);
        idle();
        @(negedge clk);
        checks++;
        if (n != 33) begin errors++; $display("FAIL postreset_stall_cycles got %0d exp 33", n); end
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL postreset_mult got hi %h lo %h exp hi ffffffff lo fffffffa", bus.hi, bus.lo);
        end
        next_cycle();
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        repeat (2) next_cycle();
        test_reset();
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        test_alu();
        test_mem();
        test_mdu_ops();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Parametrised execute stage that extends the single-cycle ALU/load-store address path with an iterative multiply/divide unit and architectural HI/LO registers. It sits between ID and MEM. It keeps the combinational ALU, branch-link and memory-request outputs. MULT/MULTU/DIV/DIVU are multi-cycle: the block raises `stall` to freeze the upstream pipeline until the result is committed to HI/LO.

## Interface
- `WIDTH`, 32: datapath width; also the iteration count of the MDU.
- `OPW`, 5: `aluop` width.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: kill the instruction in EX; aborts any MDU operation in flight.
- `in_valid` in 1: EX holds a valid instruction.
- `pc` in WIDTH: PC of the EX instruction.
- `aluop` in OPW: operation code; codes come from the shared package.
- `opr1`, `opr2` in WIDTH: source operands. For shifts, `opr1[log2(WIDTH)-1:0]` is the shift amount.
- `offset` in WIDTH: sign-extended load/store offset.
- `alures` out WIDTH: combinational result.
- `m_wen` out 1, `m_addr` out WIDTH, `m_dout` out WIDTH: combinational memory request.
- `stall` out 1: freeze IF/ID/EX this cycle.
- `hi`, `lo` out WIDTH: registered HI/LO.

## Operation
- **Single-cycle ops (SLL, SRL, SRA, ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, JAL).**
  - `alures` is computed combinationally; JAL yields `pc+8`.
  - Unknown op gives `alures=0`.
- **Memory ops.**
  - LW: `m_addr = opr1+offset`.
  - SW: additionally `m_dout = opr2` and `m_wen = 1`.
  - Otherwise all three are 0.
  - All memory outputs are gated by `in_valid & ~flush`.
- **MFHI/MFLO:** `alures = hi` / `lo`.
- **MTHI/MTLO:** write `opr1` to HI/LO at the clock edge, when `in_valid & ~flush` and state is IDLE.
- **FSM states: IDLE, BUSY, DONE.**
  - IDLE→BUSY when `in_valid & ~flush` and `aluop` is an MDU op. Operands are latched and the counter is loaded with WIDTH-1.
  - BUSY: one radix-2 step per cycle (shift-add multiply or restoring divide) on operand magnitudes. The counter decrements; BUSY→DONE when the counter is 0.
  - DONE→IDLE unconditionally. HI/LO are written at this edge.
- **MULT/MULTU:** {HI,LO} = full 2·WIDTH product.
- **DIV/DIVU:** LO = quotient, HI = remainder.
- **Signed ops.**
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - MIN/−1 gives LO=MIN, HI=0.
- **Divide by zero:** LO = all ones, HI = dividend. Latency is unchanged.
- **`stall`** = (IDLE & `in_valid` & ~`flush` & MDU op) | BUSY. It is 0 in DONE, so the instruction leaves EX at the end of DONE.
- **Flush.**
  - In BUSY or DONE: the next edge goes to IDLE and HI/LO are not written.
  - In IDLE: nothing is accepted.
- **Reset (any time, including mid-operation):** state IDLE, counter 0, HI=LO=0, latched operands 0. With `resetn` low, `stall=0`.

## Timing
- MDU op presented in cycle T:
  - `stall` is high in cycles T..T+WIDTH (WIDTH+1 cycles).
  - DONE is in cycle T+WIDTH+1.
  - HI/LO are visible from T+WIDTH+2.
- MFHI in the cycle after DONE reads the new value; no bypass is needed.
- Back-to-back MDU ops: the second is accepted in IDLE at T+WIDTH+2 at the earliest.
- MTHI in cycle C is visible to MFHI in C+1.
- `alures` and `m_*` have zero latency; `hi`/`lo` are direct register outputs.

## Structure
- **Shared defines package:**
  - all `ALU_*` codes widened to OPW, including new ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO;
  - the FSM state encoding.
- **Sub-module `md_iter`:**
  - iterative unsigned multiplier/divider: ports start, is_div, a, b, busy, done, hi_res, lo_res;
  - sign correction and divide-by-zero handling.
- **`ex_mdu` itself:** keeps the ALU, address path, HI/LO registers and the FSM/stall.

## Test plan
- WIDTH=32, MULT −3×5:
  - `stall` high for 33 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 100/7 → LO=14, HI=2.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 5/0 → LO=0xFFFFFFFF, HI=5 after the full 33-cycle stall.
- MTHI 0x1234 then MULT 2×3, with `flush` asserted in the 10th BUSY cycle:
  - `stall` drops the next cycle;
  - HI stays 0x1234, LO unchanged;
  - a following MFHI returns 0x1234.
- Reset and memory ops:
  - `resetn` low mid-DIV → HI=LO=0, `stall=0`, a fresh MULT then completes normally;
  - SW with opr1=0x100, offset=−4, opr2=0xAB → `m_addr`=0xFC, `m_dout`=0xAB, `m_wen`=1.
